// File: rtl/beacon_freq_transmitter.sv
// Frequency-coded beacon emitter: bursts of a square-wave tone (F1/F2/F3) followed by a silent gap.
// Optional IR carrier gating enabled with `define BEACON_CARRIER_EN.
module beacon_freq_transmitter #(
  parameter int unsigned CLK_HZ        = 100000000,
  parameter int unsigned F1_HZ         = 1000,
  parameter int unsigned F2_HZ         = 2000,
  parameter int unsigned F3_HZ         = 3000,
  parameter int unsigned BURST_PERIODS = 50,
  parameter int unsigned GAP_CLKS      = 5000000,
  parameter int unsigned CARRIER_HZ    = 38000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] freq_sel,
  input  logic       repeat_en,
  output logic       tx_out,
  output logic       tx_env,
  output logic       busy,
  output logic       done,
  output logic [1:0] code_active
);

  localparam int unsigned HALF1    = CLK_HZ / (2 * F1_HZ);
  localparam int unsigned HALF2    = CLK_HZ / (2 * F2_HZ);
  localparam int unsigned HALF3    = CLK_HZ / (2 * F3_HZ);
  localparam int unsigned HALF12   = (HALF1 > HALF2) ? HALF1 : HALF2;
  localparam int unsigned HALF_MAX = (HALF12 > HALF3) ? HALF12 : HALF3;
  localparam int unsigned CNT_MAX  = (HALF_MAX > GAP_CLKS) ? HALF_MAX - 1 : GAP_CLKS - 1;
  localparam int unsigned CNT_W    = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int unsigned PH_MAX   = 2 * BURST_PERIODS - 1;
  localparam int unsigned PH_W     = (PH_MAX > 0) ? $clog2(PH_MAX + 1) : 1;

  if (HALF1 < 1 || HALF2 < 1 || HALF3 < 1) begin : g_bad_half
    $error("beacon_freq_transmitter: tone half-period below one clock");
  end

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_half_m1;
  logic [PH_W-1:0]  r_phase, w_phase_nxt;
  logic             r_env, w_env_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [1:0]       r_code, w_code_nxt;
  logic             r_tx_out, w_tx_out_nxt;
  logic             w_burst_entry;

  // Half-period length for the latched tone code
  always_comb begin
    case (r_code)
      2'd1:    w_half_m1 = CNT_W'(HALF1 - 1);
      2'd2:    w_half_m1 = CNT_W'(HALF2 - 1);
      default: w_half_m1 = CNT_W'(HALF3 - 1);
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_phase_nxt   = r_phase;
    w_env_nxt     = r_env;
    w_code_nxt    = r_code;
    w_done_nxt    = 1'b0;
    w_burst_entry = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && freq_sel != 2'd0) begin
          w_state_nxt   = S_BURST;
          w_code_nxt    = freq_sel;
          w_cnt_nxt     = '0;
          w_phase_nxt   = '0;
          w_env_nxt     = 1'b1;
          w_burst_entry = 1'b1;
        end
      end
      S_BURST: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_code_nxt  = 2'd0;
          w_env_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_phase_nxt = '0;
        end else if (r_cnt == w_half_m1) begin
          w_cnt_nxt = '0;
          if (r_phase == PH_W'(PH_MAX)) begin
            w_state_nxt = S_GAP;
            w_env_nxt   = 1'b0;
            w_phase_nxt = '0;
          end else begin
            w_phase_nxt = r_phase + PH_W'(1);
            w_env_nxt   = ~r_env;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_code_nxt  = 2'd0;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_W'(GAP_CLKS - 1)) begin
          w_cnt_nxt = '0;
          if (repeat_en) begin
            w_state_nxt   = S_BURST;
            w_env_nxt     = 1'b1;
            w_burst_entry = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_code_nxt  = 2'd0;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_code_nxt  = 2'd0;
        w_env_nxt   = 1'b0;
        w_cnt_nxt   = '0;
        w_phase_nxt = '0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

`ifdef BEACON_CARRIER_EN
  localparam int unsigned CAR_HALF = CLK_HZ / (2 * CARRIER_HZ);
  localparam int unsigned CAR_W    = (CAR_HALF > 1) ? $clog2(CAR_HALF) : 1;

  if (CAR_HALF < 1) begin : g_bad_carrier
    $error("beacon_freq_transmitter: carrier half-period below one clock");
  end

  logic             r_car, w_car_nxt;
  logic [CAR_W-1:0] r_car_cnt, w_car_cnt_nxt;

  // Carrier restarts high on each burst entry and only runs while bursting
  always_comb begin
    w_car_nxt     = r_car;
    w_car_cnt_nxt = r_car_cnt;
    if (w_burst_entry) begin
      w_car_nxt     = 1'b1;
      w_car_cnt_nxt = '0;
    end else if (w_state_nxt == S_BURST) begin
      if (r_car_cnt == CAR_W'(CAR_HALF - 1)) begin
        w_car_nxt     = ~r_car;
        w_car_cnt_nxt = '0;
      end else begin
        w_car_cnt_nxt = r_car_cnt + CAR_W'(1);
      end
    end else begin
      w_car_nxt     = 1'b0;
      w_car_cnt_nxt = '0;
    end
    w_tx_out_nxt = w_env_nxt & w_car_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_car     <= 1'b0;
      r_car_cnt <= '0;
    end else begin
      r_car     <= w_car_nxt;
      r_car_cnt <= w_car_cnt_nxt;
    end
  end
`else
  always_comb w_tx_out_nxt = w_env_nxt;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_phase  <= '0;
      r_env    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_code   <= 2'd0;
      r_tx_out <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_phase  <= w_phase_nxt;
      r_env    <= w_env_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_code   <= w_code_nxt;
      r_tx_out <= w_tx_out_nxt;
    end
  end

  assign tx_out      = r_tx_out;
  assign tx_env      = r_env;
  assign busy        = r_busy;
  assign done        = r_done;
  assign code_active = r_code;

endmodule

// File: doc/beacon_freq_transmitter.md
Name: beacon_freq_transmitter

Overview:
- Beacon emitter for the frequency-coded signalling link. It is the transmit end of the channel that Frequency_Signal_Detection decodes into forward/left/right 2-bit codes.
- Generates bursts of a square wave at one of three selectable frequencies. Each burst is followed by a silent gap, either once or repeated.
- Drives the beacon LED/IR pin on a Pmod header and reports busy/done to the controlling logic.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- F1_HZ, 1000, tone frequency for code 2'b01.
- F2_HZ, 2000, tone frequency for code 2'b10.
- F3_HZ, 3000, tone frequency for code 2'b11.
- BURST_PERIODS, 50, full tone periods per burst (≥1).
- GAP_CLKS, 5000000, silent clocks after each burst (≥1).
- CARRIER_HZ, 38000, IR carrier frequency (used only with the optional feature).

Ports:
- clock, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle request to begin transmission.
- stop, input, 1, synchronous abort.
- freq_sel, input, 2, tone code: 0 = none, 1..3 = F1..F3.
- repeat_en, input, 1, when 1, burst/gap repeats until stop.
- tx_out, output, 1, beacon pin drive.
- tx_env, output, 1, tone envelope (unmodulated square wave).
- busy, output, 1, high while in BURST or GAP.
- done, output, 1, one-cycle pulse on normal completion.
- code_active, output, 2, latched code being sent; 0 when idle.

Behaviour:
- Derived constants: HALFn = CLK_HZ/(2*Fn_HZ), integer division. HALFn ≥ 1 is required (elaboration-time check). Counters are sized by $clog2 of their maximum value.
- Reset (async, active-high): state=IDLE, tx_out=0, tx_env=0, busy=0, done=0, code_active=0, all counters cleared.
- States: IDLE, BURST, GAP.
- IDLE: tx_out=tx_env=0, busy=0.
  - start=1 with freq_sel≠0 → latch freq_sel into code_active and go to BURST.
  - start with freq_sel=0 is ignored: no busy, no done.
- Latency: start sampled at edge k. From cycle k+1, busy=1 and tx_env=1.
- BURST:
  - tx_env starts high and toggles every HALF(code_active) clocks.
  - Burst lasts exactly 2*BURST_PERIODS*HALF clocks, ending after a low half-period. Then → GAP.
- GAP:
  - tx_env=tx_out=0 for exactly GAP_CLKS clocks.
  - At the end, if repeat_en=1 (sampled in the last gap cycle) → BURST with the same code_active, and a new high phase starts next cycle.
  - Otherwise → IDLE. done=1 for one cycle coincident with the first IDLE cycle; busy=0 in that cycle.
- start while busy: ignored. freq_sel changes while busy: ignored until the next start.
- stop=1 in BURST or GAP:
  - Next cycle is IDLE with tx_out=tx_env=0, busy=0, code_active=0.
  - No done pulse.
  - stop has priority over the end-of-gap transition and over repeat.
- stop and start together in IDLE: start wins.
- Reset mid-burst: outputs go low immediately (asynchronously); no done.
- tx_out = tx_env when BEACON_CARRIER_EN is undefined.

Optional Feature:
- Macro: BEACON_CARRIER_EN.
- Defined:
  - Adds a carrier counter with half-period CLK_HZ/(2*CARRIER_HZ).
  - The counter resets to phase-high on every BURST entry and free-runs only in BURST.
  - tx_out = tx_env AND carrier, for direct IR-LED drive.
  - tx_env is unchanged.
- Undefined: no carrier logic; tx_out = tx_env.

Test Plan:
Bench parameters: CLK_HZ=1200, F1=100 (HALF 6), F2=200 (HALF 3), F3=300 (HALF 2), BURST_PERIODS=2, GAP_CLKS=4.
- freq_sel=1, start pulse, repeat_en=0 → tx_env sequence 6H,6L,6H,6L then 4L; busy high for 28 cycles; done pulse in cycle 29 after start; code_active=1 during, 0 after.
- freq_sel=3, repeat_en=1 → pattern 2H,2L,2H,2L,4L repeats with period 12; done never pulses; stop asserted mid-second-burst → next cycle busy=0, tx_out=0, no done.
- start with freq_sel=0 → busy stays 0, done stays 0, tx_out stays 0 for 50 cycles.
- freq_sel=2 start, then at cycle 5 freq_sel=1 and start=1 again → burst stays at HALF 3 (total busy 16 cycles); second start ignored.
- Assert reset at cycle 7 of an F1 burst → tx_out, tx_env, busy drop before the next edge; after release, IDLE; new start behaves as the first scenario.
- With BEACON_CARRIER_EN, CARRIER_HZ=200 (half 3), F1 burst → tx_out = 3H,3L during tx_env high phases, 0 during low phases and gap.
